// File: rtl/alu_arbiter_if.sv
// One requester channel of the ALU arbiter: operation request plus result handshake.
interface alu_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [OP_W-1:0]   op;
  logic              rsp_valid;
  logic              rsp_ready;

  // Requester side
  modport master (
    output valid, a, b, op, rsp_ready,
    input  ready, rsp_valid
  );

  // Arbiter side
  modport slave (
    input  valid, a, b, op, rsp_ready,
    output ready, rsp_valid
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration. One transaction in flight: accept, drive ALU for one cycle,
// then hold the registered result until the owner takes it.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational, ready only here
// EXEC  | latched operands on the ALU; result captured at the end of this cycle
// RESP  | result held for the owner until its rsp_ready
module alu_arbiter #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_arbiter_if.slave      req0_if,
  alu_arbiter_if.slave      req1_if,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_out_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;

  logic              grant_any;
  logic              grant1;
  logic              accept;
  logic              own_rsp_ready;

  // Round-robin grant: on a tie the port that did not win last time goes
  always_comb begin
    grant_any = 1'b0;
    grant1    = 1'b0;
    if (req0_if.valid && req1_if.valid) begin
      grant_any = 1'b1;
      grant1    = ~last_grant_q;
    end else if (req1_if.valid) begin
      grant_any = 1'b1;
      grant1    = 1'b1;
    end else if (req0_if.valid) begin
      grant_any = 1'b1;
    end
  end

  assign accept        = (state_q == IDLE) && grant_any;
  assign req0_if.ready = accept && !grant1;
  assign req1_if.ready = accept && grant1;
  assign own_rsp_ready = owner_q ? req1_if.rsp_ready : req0_if.rsp_ready;

  // Transaction FSM with registered operands, result and response valids
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= grant1;
            a_q     <= grant1 ? req1_if.a  : req0_if.a;
            b_q     <= grant1 ? req1_if.b  : req0_if.b;
            op_q    <= grant1 ? req1_if.op : req0_if.op;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q   <= alu_out_i;
          rsp_zero_q   <= (alu_out_i == '0);
          last_grant_q <= owner_q;
          rsp0_valid_q <= ~owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (own_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_if.rsp_valid = rsp0_valid_q;
  assign req1_if.rsp_valid = rsp1_valid_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_zero_o        = rsp_zero_q;
  assign alu_a_o           = a_q;
  assign alu_b_o           = b_q;
  assign alu_op_o          = op_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single transactions plus
// hand-written arbitration, stall and reset sequences.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rsp_data, alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic       rsp_zero, busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter_if #(.DATA_W(8), .OP_W(4)) p0_if ();
  alu_arbiter_if #(.DATA_W(8), .OP_W(4)) p1_if ();

  alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req0_if   (p0_if),
    .req1_if   (p1_if),
    .rsp_data_o(rsp_data),
    .rsp_zero_o(rsp_zero),
    .alu_a_o   (alu_a),
    .alu_b_o   (alu_b),
    .alu_op_o  (alu_op),
    .alu_out_i (alu_out),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  // External ALU: add, sub, and, or; anything else yields 0
  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0010: alu_out = alu_a & alu_b;
      4'b0011: alu_out = alu_a | alu_b;
      default: alu_out = 8'h00;
    endcase
  end

  typedef struct {
    int         port;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] exp_data;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    if (p == 0) begin
      p0_if.valid = v; p0_if.a = a; p0_if.b = b; p0_if.op = op;
    end else begin
      p1_if.valid = v; p1_if.a = a; p1_if.b = b; p1_if.op = op;
    end
  endtask

  task automatic set_rsp_ready(input int p, input logic r);
    if (p == 0) p0_if.rsp_ready = r;
    else        p1_if.rsp_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transaction on one port, other port idle; operands corrupted after accept
  task automatic do_txn(input int p, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input logic [7:0] exp_data, input logic exp_zero);
    set_req(p, 1'b1, a, b, op);
    #1;
    chk("ready_own_idle", (p == 1) ? p1_if.ready : p0_if.ready, 1);
    chk("ready_other_idle", (p == 1) ? p0_if.ready : p1_if.ready, 0);
    chk("busy_idle", busy, 0);
    step();
    set_req(p, 1'b0, ~a, ~b, op ^ 4'hF);
    #1;
    chk("busy_exec", busy, 1);
    chk("ready_exec", (p == 1) ? p1_if.ready : p0_if.ready, 0);
    chk("alu_a_exec", alu_a, a);
    chk("alu_b_exec", alu_b, b);
    chk("alu_op_exec", alu_op, op);
    chk("rsp_valid_exec", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
    step();
    chk("rsp_valid_own", (p == 1) ? p1_if.rsp_valid : p0_if.rsp_valid, 1);
    chk("rsp_valid_other", (p == 1) ? p0_if.rsp_valid : p1_if.rsp_valid, 0);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_zero", rsp_zero, exp_zero);
    set_rsp_ready(p, 1'b1);
    step();
    set_rsp_ready(p, 1'b0);
    chk("rsp_valid_after", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    vecs[0] = '{0, 8'h05, 8'h03, 4'b0000, 8'h08, 1'b0};
    vecs[1] = '{1, 8'h00, 8'h01, 4'b0001, 8'hFF, 1'b0};
    vecs[2] = '{1, 8'hF0, 8'hF0, 4'b0001, 8'h00, 1'b1};
    vecs[3] = '{0, 8'h0C, 8'h0A, 4'b0010, 8'h08, 1'b0};
    vecs[4] = '{1, 8'h0C, 8'h0A, 4'b0011, 8'h0E, 1'b0};
    vecs[5] = '{0, 8'h3C, 8'h01, 4'b0111, 8'h00, 1'b1};
    vecs[6] = '{0, 8'hFF, 8'h02, 4'b0000, 8'h01, 1'b0};
    vecs[7] = '{1, 8'h80, 8'h80, 4'b0000, 8'h00, 1'b1};

    rst = 1'b1;
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    p0_if.rsp_ready = 1'b0;
    p1_if.rsp_ready = 1'b0;
    step();
    step();
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_ready", {p1_if.ready, p0_if.ready}, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_data, vecs[i].exp_zero);

    // Both requesting every cycle after reset: port 0 first, then strict alternation
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 8'h0C, 8'h0A, 4'b0010);
    set_req(1, 1'b1, 8'h0C, 8'h0A, 4'b0011);
    p0_if.rsp_ready = 1'b1;
    p1_if.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", p0_if.ready, (k % 2 == 0) ? 1 : 0);
      chk("rr_ready1", p1_if.ready, (k % 2 == 1) ? 1 : 0);
      step();
      step();
      chk("rr_rsp0_valid", p0_if.rsp_valid, (k % 2 == 0) ? 1 : 0);
      chk("rr_rsp1_valid", p1_if.rsp_valid, (k % 2 == 1) ? 1 : 0);
      chk("rr_rsp_data", rsp_data, (k % 2 == 0) ? 32'h08 : 32'h0E);
      step();
    end
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    p0_if.rsp_ready = 1'b0;
    p1_if.rsp_ready = 1'b0;
    step();

    // Response stall: req1 waits while port 0 holds its result
    set_req(0, 1'b1, 8'h01, 8'h02, 4'b0000);
    #1;
    chk("stall_ready0", p0_if.ready, 1);
    step();
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b1, 8'h10, 8'h01, 4'b0001);
    #1;
    chk("stall_ready1_exec", p1_if.ready, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp0_valid", p0_if.rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 8'h03);
      chk("stall_ready1", p1_if.ready, 0);
      step();
    end
    p0_if.rsp_ready = 1'b1;
    #1;
    chk("stall_rsp0_valid_last", p0_if.rsp_valid, 1);
    step();
    p0_if.rsp_ready = 1'b0;
    #1;
    chk("stall_rsp0_cleared", p0_if.rsp_valid, 0);
    chk("stall_ready1_idle", p1_if.ready, 1);
    step();
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    step();
    chk("stall_rsp1_valid", p1_if.rsp_valid, 1);
    chk("stall_rsp1_data", rsp_data, 8'h0F);
    p1_if.rsp_ready = 1'b1;
    step();
    p1_if.rsp_ready = 1'b0;

    // Reset during EXEC aborts the transaction
    set_req(0, 1'b1, 8'hAA, 8'h55, 4'b0000);
    step();
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    chk("abort_busy_exec", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_rsp_valid", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rsp_zero", rsp_zero, 0);
    chk("abort_busy", busy, 0);
    chk("abort_alu_a", alu_a, 0);
    chk("abort_alu_op", alu_op, 0);
    step();
    chk("abort_no_rsp", {p1_if.rsp_valid, p0_if.rsp_valid}, 0);
    do_txn(0, 8'h22, 8'h11, 4'b0000, 8'h33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
